effect_param_editor: RTL and testbench
======================================

// Module: effect_param_editor
// PURPOSE
// Push-button editor for the effect parameters that the 7-segment display controller shows.
// SW[3:0] selects the effect parameter. The up/down KEYs step it, with debounce and auto-repeat.
// It owns the registers that feed the distortion, tremolo, ring mod, echo, vibrato and slapback
// (sb) effects, and the display controller.
// PARAMETERS
// DEBOUNCE_CYCLES  500000  cycles a synchronised key must be stable before a level change is accepted
// HOLD_CYCLES      25000000  press duration before auto-repeat starts
// REPEAT_CYCLES    5000000   auto-repeat period once repeating
// PORTS
// clk               in   1   system clock
// reset             in   1   synchronous, active-high
// SW                in   10  SW[3:0] parameter select (0..7 valid); SW[9]=1 locks editing
// key_up_n          in   1   raw KEY, active-low, asynchronous
// key_down_n        in   1   raw KEY, active-low, asynchronous
// threshold         out  32  signed; sel 0
// gain              out  16  signed; sel 1
// tr_freq           out  32  sel 2
// ring_freq         out  32  sel 3
// echo_delay_time   out  32  sel 4, samples @48 kHz
// echo_delay_volume out  32  sel 5
// vib_freq          out  32  sel 6
// sb_delay_time     out  32  sel 7, samples @48 kHz
// param_changed     out  1   one-cycle pulse when any output register changes value
// BEHAVIOUR
// - Range table (min/max/step/default): threshold 100/30000/100/5000; gain 1/99/1/10;
//   tr_freq 1000/97000/1000/10000; ring_freq 160/15600/160/1600;
//   echo_delay_time 4800/96000/4800/24000; echo_delay_volume 0/9/1/5;
//   vib_freq 1000/97000/1000/10000; sb_delay_time 480/48000/480/4800.
// - Reset: every output = its default, param_changed=0, FSM=WAIT_RELEASE, debouncers cleared to released.
// - Input path: each key is 2-FF synchronised and inverted, then debounced. Debounced level
//   changes only after DEBOUNCE_CYCLES consecutive equal samples.
// - FSM: IDLE, STEP, HOLD, REPEAT, WAIT_RELEASE.
//   IDLE: exactly one debounced key pressed -> STEP. Both pressed -> restore selected param to default,
//     -> WAIT_RELEASE.
//   STEP: apply one step in the pressed direction (1 cycle), -> HOLD. Counter cleared.
//   HOLD: key released -> IDLE. Counter reaches HOLD_CYCLES-1 -> REPEAT with one step applied.
//   REPEAT: step every REPEAT_CYCLES while held. Release -> IDLE.
//   WAIT_RELEASE: stays until both debounced keys are released -> IDLE.
// - Latency: the register updates on the clock edge after the debounced press is first seen in IDLE.
// - Arithmetic: compare in 33-bit (unsigned fields) or sign-extended (signed fields).
//   Up: v+step>max ? max : v+step. Down: v<min+step ? min : v-step. Saturated -> no change.
// - param_changed pulses only if the stored value actually differs, so saturated presses give no pulse.
// - Second key pressed while in HOLD/REPEAT: abort the step, -> WAIT_RELEASE; no default restore.
// - SW[3:0] changes while in STEP/HOLD/REPEAT: -> WAIT_RELEASE. Never step the newly selected param mid-hold.
// - SW[3:0]>7 or SW[9]=1: presses are consumed but no register changes (IDLE->WAIT_RELEASE).
// - Reset mid-hold: defaults restored. A key still held after reset produces no step until released.
// STRUCTURE
// - Package effect_param_pkg: localparams for each param's MIN/MAX/STEP/DEFAULT, a typedef enum for
//   PARAM_SEL (THRESH..SB_DELAY), and the FSM state enum. The display controller reuses the same
//   select encoding.
// - Sub-module key_debouncer (sync + stable counter, param DEBOUNCE_CYCLES), instantiated twice.
// - One shared step/saturate datapath muxed by select. Eight output registers with per-field enables.
// TESTING  (bench: DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=5)
// - Reset, sel=1, tap up 10 cycles -> gain 10->11, one param_changed pulse, no other output moves.
// - Glitch: 2-cycle low pulses on key_up_n, sel=0 -> threshold stays 5000, no pulse.
// - sel=5, hold down 60 cycles -> volume 5,4 (STEP), then repeats down to 0, holds at 0, no further pulses.
// - sel=4 at 96000, press up -> stays 96000, no pulse. Press down -> 91200.
// - sel=3, step ring_freq to 1920, press both keys -> 1600. Release one, re-press -> no change until both released.
// - Hold up on sel=6, change SW to 2 mid-hold -> vib_freq stops, tr_freq unchanged. Assert reset mid-hold -> all defaults, no step until release.

Source files
------------

// File: rtl/effect_param_pkg.sv
// Shared definitions for the effect parameter editor: select encoding, FSM states,
// per-parameter range table and the saturating step helper.
package effect_param_pkg;

    typedef enum logic [2:0] {
        THRESH    = 3'd0,
        GAIN      = 3'd1,
        TR_FREQ   = 3'd2,
        RING_FREQ = 3'd3,
        ECHO_TIME = 3'd4,
        ECHO_VOL  = 3'd5,
        VIB_FREQ  = 3'd6,
        SB_DELAY  = 3'd7
    } param_sel_e;

    typedef enum logic [2:0] {
        IDLE,
        STEP,
        HOLD,
        REPEAT,
        WAIT_RELEASE
    } edit_state_e;

    // Wide enough that v+step never overflows for either signed or unsigned 32-bit fields.
    localparam int VAL_W = 34;
    typedef logic signed [VAL_W-1:0] pval_t;

    localparam pval_t THRESH_MIN = 34'sd100;
    localparam pval_t THRESH_MAX = 34'sd30000;
    localparam pval_t THRESH_STEP = 34'sd100;
    localparam pval_t THRESH_DEF = 34'sd5000;

    localparam pval_t GAIN_MIN = 34'sd1;
    localparam pval_t GAIN_MAX = 34'sd99;
    localparam pval_t GAIN_STEP = 34'sd1;
    localparam pval_t GAIN_DEF = 34'sd10;

    localparam pval_t TR_MIN = 34'sd1000;
    localparam pval_t TR_MAX = 34'sd97000;
    localparam pval_t TR_STEP = 34'sd1000;
    localparam pval_t TR_DEF = 34'sd10000;

    localparam pval_t RING_MIN = 34'sd160;
    localparam pval_t RING_MAX = 34'sd15600;
    localparam pval_t RING_STEP = 34'sd160;
    localparam pval_t RING_DEF = 34'sd1600;

    localparam pval_t ECHO_T_MIN = 34'sd4800;
    localparam pval_t ECHO_T_MAX = 34'sd96000;
    localparam pval_t ECHO_T_STEP = 34'sd4800;
    localparam pval_t ECHO_T_DEF = 34'sd24000;

    localparam pval_t ECHO_V_MIN = 34'sd0;
    localparam pval_t ECHO_V_MAX = 34'sd9;
    localparam pval_t ECHO_V_STEP = 34'sd1;
    localparam pval_t ECHO_V_DEF = 34'sd5;

    localparam pval_t VIB_MIN = 34'sd1000;
    localparam pval_t VIB_MAX = 34'sd97000;
    localparam pval_t VIB_STEP = 34'sd1000;
    localparam pval_t VIB_DEF = 34'sd10000;

    localparam pval_t SB_MIN = 34'sd480;
    localparam pval_t SB_MAX = 34'sd48000;
    localparam pval_t SB_STEP = 34'sd480;
    localparam pval_t SB_DEF = 34'sd4800;

    function automatic pval_t param_min(input param_sel_e sel);
        pval_t r;
        case (sel)
            THRESH:    r = THRESH_MIN;
            GAIN:      r = GAIN_MIN;
            TR_FREQ:   r = TR_MIN;
            RING_FREQ: r = RING_MIN;
            ECHO_TIME: r = ECHO_T_MIN;
            ECHO_VOL:  r = ECHO_V_MIN;
            VIB_FREQ:  r = VIB_MIN;
            default:   r = SB_MIN;
        endcase
        return r;
    endfunction

    function automatic pval_t param_max(input param_sel_e sel);
        pval_t r;
        case (sel)
            THRESH:    r = THRESH_MAX;
            GAIN:      r = GAIN_MAX;
            TR_FREQ:   r = TR_MAX;
            RING_FREQ: r = RING_MAX;
            ECHO_TIME: r = ECHO_T_MAX;
            ECHO_VOL:  r = ECHO_V_MAX;
            VIB_FREQ:  r = VIB_MAX;
            default:   r = SB_MAX;
        endcase
        return r;
    endfunction

    function automatic pval_t param_step(input param_sel_e sel);
        pval_t r;
        case (sel)
            THRESH:    r = THRESH_STEP;
            GAIN:      r = GAIN_STEP;
            TR_FREQ:   r = TR_STEP;
            RING_FREQ: r = RING_STEP;
            ECHO_TIME: r = ECHO_T_STEP;
            ECHO_VOL:  r = ECHO_V_STEP;
            VIB_FREQ:  r = VIB_STEP;
            default:   r = SB_STEP;
        endcase
        return r;
    endfunction

    function automatic pval_t param_default(input param_sel_e sel);
        pval_t r;
        case (sel)
            THRESH:    r = THRESH_DEF;
            GAIN:      r = GAIN_DEF;
            TR_FREQ:   r = TR_DEF;
            RING_FREQ: r = RING_DEF;
            ECHO_TIME: r = ECHO_T_DEF;
            ECHO_VOL:  r = ECHO_V_DEF;
            VIB_FREQ:  r = VIB_DEF;
            default:   r = SB_DEF;
        endcase
        return r;
    endfunction

    // Only threshold and gain are signed; everything else is zero-extended.
    function automatic pval_t widen(input logic [31:0] raw, input param_sel_e sel);
        pval_t r;
        if (sel == THRESH || sel == GAIN) begin
            r = {{(VAL_W-32){raw[31]}}, raw};
        end else begin
            r = {{(VAL_W-32){1'b0}}, raw};
        end
        return r;
    endfunction

    function automatic pval_t step_value(input pval_t cur, input param_sel_e sel, input logic up);
        pval_t lo;
        pval_t hi;
        pval_t st;
        pval_t r;
        lo = param_min(sel);
        hi = param_max(sel);
        st = param_step(sel);
        if (up) begin
            r = (cur + st > hi) ? hi : cur + st;
        end else begin
            r = (cur < lo + st) ? lo : cur - st;
        end
        return r;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Synchronises a raw active-low key and reports a debounced pressed level, plus a flag
// that the key is released with nothing pending (used to gate re-arming the editor).
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic pressed,
    output logic released_stable
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q, sync_d;
    logic [1:0]       prime_q, prime_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sample;

    assign sample = ~sync_q[1];

    always_comb begin
        sync_d  = {sync_q[0], key_n};
        prime_d = {prime_q[0], 1'b1};
        level_d = level_q;
        cnt_d   = '0;
        if (sample != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sample;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= 2'b11;
            prime_q <= 2'b00;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            prime_q <= prime_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pressed = level_q;
    // Not trusted until the synchroniser has refilled after reset, so a key held through reset stays "busy".
    assign released_stable = prime_q[1] & ~level_q & ~sample & (cnt_q == '0);

endmodule

// File: rtl/effect_param_editor.sv
// Push-button editor for the eight effect parameters: debounced up/down keys step the
// parameter chosen by SW[3:0] with saturation, auto-repeat and a both-keys default restore.
module effect_param_editor
    import effect_param_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 5000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [9:0]         SW,
    input  logic               key_up_n,
    input  logic               key_down_n,
    output logic signed [31:0] threshold,
    output logic signed [15:0] gain,
    output logic [31:0]        tr_freq,
    output logic [31:0]        ring_freq,
    output logic [31:0]        echo_delay_time,
    output logic [31:0]        echo_delay_volume,
    output logic [31:0]        vib_freq,
    output logic [31:0]        sb_delay_time,
    output logic               param_changed
);

    logic up_lvl, dn_lvl, up_idle, dn_idle;

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
        .clk             (clk),
        .reset           (reset),
        .key_n           (key_up_n),
        .pressed         (up_lvl),
        .released_stable (up_idle)
    );

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
        .clk             (clk),
        .reset           (reset),
        .key_n           (key_down_n),
        .pressed         (dn_lvl),
        .released_stable (dn_idle)
    );

    edit_state_e state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    param_sel_e  sel_q, sel_d;
    logic        up_q, up_d;
    logic        changed_q, changed_d;
    logic [31:0] val_q [8];
    logic [31:0] val_d [8];

    param_sel_e sw_sel;
    logic       locked, sw_moved, both, held;
    logic       do_step, do_restore, wr_en;
    param_sel_e wr_sel;
    pval_t      cur, wr_val;

    assign sw_sel   = param_sel_e'(SW[2:0]);
    assign locked   = SW[9] | SW[3];
    assign sw_moved = SW[3] | (SW[2:0] != sel_q);
    assign both     = up_lvl & dn_lvl;
    assign held     = up_q ? up_lvl : dn_lvl;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        up_d       = up_q;
        do_step    = 1'b0;
        do_restore = 1'b0;
        case (state_q)
            IDLE: begin
                if (up_lvl ^ dn_lvl) begin
                    if (locked) begin
                        state_d = WAIT_RELEASE;
                    end else begin
                        sel_d   = sw_sel;
                        up_d    = up_lvl;
                        state_d = STEP;
                    end
                end else if (both) begin
                    do_restore = ~locked;
                    state_d    = WAIT_RELEASE;
                end
            end
            STEP: begin
                if (sw_moved || both) begin
                    state_d = WAIT_RELEASE;
                end else begin
                    do_step = 1'b1;
                    cnt_d   = '0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (sw_moved || both) begin
                    state_d = WAIT_RELEASE;
                end else if (!held) begin
                    state_d = IDLE;
                end else if (cnt_q == 32'(HOLD_CYCLES - 1)) begin
                    do_step = 1'b1;
                    cnt_d   = '0;
                    state_d = REPEAT;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            REPEAT: begin
                if (sw_moved || both) begin
                    state_d = WAIT_RELEASE;
                end else if (!held) begin
                    state_d = IDLE;
                end else if (cnt_q == 32'(REPEAT_CYCLES - 1)) begin
                    do_step = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            WAIT_RELEASE: begin
                if (up_idle && dn_idle) begin
                    state_d = IDLE;
                end
            end
            default: state_d = WAIT_RELEASE;
        endcase
    end

    // Single shared step/saturate datapath; the restore path only fires from IDLE.
    always_comb begin
        wr_sel    = (state_q == IDLE) ? sw_sel : sel_q;
        cur       = widen(val_q[wr_sel], wr_sel);
        wr_val    = do_restore ? param_default(wr_sel) : step_value(cur, wr_sel, up_q);
        wr_en     = do_step | do_restore;
        changed_d = wr_en & (wr_val != cur);
    end

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_field
            always_comb begin
                val_d[gi] = val_q[gi];
                if (wr_en && (wr_sel == param_sel_e'(3'(gi)))) begin
                    val_d[gi] = wr_val[31:0];
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    val_q[gi] <= 32'(param_default(param_sel_e'(3'(gi))));
                end else begin
                    val_q[gi] <= val_d[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= WAIT_RELEASE;
            cnt_q     <= '0;
            sel_q     <= THRESH;
            up_q      <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            up_q      <= up_d;
            changed_q <= changed_d;
        end
    end

    assign threshold         = val_q[THRESH];
    assign gain              = val_q[GAIN][15:0];
    assign tr_freq           = val_q[TR_FREQ];
    assign ring_freq         = val_q[RING_FREQ];
    assign echo_delay_time   = val_q[ECHO_TIME];
    assign echo_delay_volume = val_q[ECHO_VOL];
    assign vib_freq          = val_q[VIB_FREQ];
    assign sb_delay_time     = val_q[SB_DELAY];
    assign param_changed     = changed_q;

endmodule

// File: tb/tb_effect_param_editor.sv
// Directed self-checking bench for effect_param_editor with short debounce/hold/repeat timings.
module tb_effect_param_editor;

    logic               clk = 1'b0;
    logic               reset;
    logic [9:0]         SW;
    logic               key_up_n;
    logic               key_down_n;
    logic signed [31:0] threshold;
    logic signed [15:0] gain;
    logic [31:0]        tr_freq, ring_freq, echo_delay_time, echo_delay_volume, vib_freq, sb_delay_time;
    logic               param_changed;

    int vectors = 0;
    int miscompares = 0;
    int pulses = 0;

    effect_param_editor #(
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (20),
        .REPEAT_CYCLES   (5)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .SW                (SW),
        .key_up_n          (key_up_n),
        .key_down_n        (key_down_n),
        .threshold         (threshold),
        .gain              (gain),
        .tr_freq           (tr_freq),
        .ring_freq         (ring_freq),
        .echo_delay_time   (echo_delay_time),
        .echo_delay_volume (echo_delay_volume),
        .vib_freq          (vib_freq),
        .sb_delay_time     (sb_delay_time),
        .param_changed     (param_changed)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (param_changed === 1'b1) pulses++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tap(input logic up, input logic dn, input int n);
        key_up_n = ~up;
        key_down_n = ~dn;
        tick(n);
        key_up_n = 1'b1;
        key_down_n = 1'b1;
        tick(30);
    endtask

    task automatic test_reset;
        reset = 1'b1; SW = 10'd0; key_up_n = 1'b1; key_down_n = 1'b1;
        tick(3);
        reset = 1'b0;
        vectors++; if (threshold !== 32'sd5000) begin miscompares++; $display("FAIL reset_threshold: got %0d expected 5000", threshold); end
        vectors++; if (gain !== 16'sd10) begin miscompares++; $display("FAIL reset_gain: got %0d expected 10", gain); end
        vectors++; if (tr_freq !== 32'd10000) begin miscompares++; $display("FAIL reset_tr: got %0d expected 10000", tr_freq); end
        vectors++; if (ring_freq !== 32'd1600) begin miscompares++; $display("FAIL reset_ring: got %0d expected 1600", ring_freq); end
        vectors++; if (echo_delay_time !== 32'd24000) begin miscompares++; $display("FAIL reset_echo_t: got %0d expected 24000", echo_delay_time); end
        vectors++; if (echo_delay_volume !== 32'd5) begin miscompares++; $display("FAIL reset_echo_v: got %0d expected 5", echo_delay_volume); end
        vectors++; if (vib_freq !== 32'd10000) begin miscompares++; $display("FAIL reset_vib: got %0d expected 10000", vib_freq); end
        vectors++; if (sb_delay_time !== 32'd4800) begin miscompares++; $display("FAIL reset_sb: got %0d expected 4800", sb_delay_time); end
        vectors++; if (param_changed !== 1'b0) begin miscompares++; $display("FAIL reset_pulse: got %b expected 0", param_changed); end
        tick(10);
        $display("reset: defaults checked");
    endtask

    task automatic test_tap;
        int p0;
        SW = 10'd1; p0 = pulses;
        tap(1'b1, 1'b0, 10);
        vectors++; if (gain !== 16'sd11) begin miscompares++; $display("FAIL tap_gain: got %0d expected 11", gain); end
        vectors++; if (pulses - p0 !== 1) begin miscompares++; $display("FAIL tap_pulses: got %0d expected 1", pulses - p0); end
        vectors++; if (threshold !== 32'sd5000 || tr_freq !== 32'd10000 || ring_freq !== 32'd1600 || echo_delay_time !== 32'd24000
                       || echo_delay_volume !== 32'd5 || vib_freq !== 32'd10000 || sb_delay_time !== 32'd4800) begin
            miscompares++; $display("FAIL tap_others: thr=%0d tr=%0d ring=%0d et=%0d ev=%0d vib=%0d sb=%0d expected defaults",
                                    threshold, tr_freq, ring_freq, echo_delay_time, echo_delay_volume, vib_freq, sb_delay_time);
        end
        $display("tap: sel=1 up -> gain=%0d", gain);
    endtask

    task automatic test_glitch;
        int p0;
        SW = 10'd0; p0 = pulses;
        repeat (4) begin
            key_up_n = 1'b0; tick(2);
            key_up_n = 1'b1; tick(3);
        end
        tick(20);
        vectors++; if (threshold !== 32'sd5000) begin miscompares++; $display("FAIL glitch_threshold: got %0d expected 5000", threshold); end
        vectors++; if (pulses - p0 !== 0) begin miscompares++; $display("FAIL glitch_pulses: got %0d expected 0", pulses - p0); end
        $display("glitch: threshold=%0d", threshold);
    endtask

    task automatic test_lock;
        int p0;
        p0 = pulses;
        SW = 10'h201; tap(1'b1, 1'b0, 10);
        SW = 10'h009; tap(1'b1, 1'b0, 10);
        SW = 10'h009; tap(1'b1, 1'b1, 10);
        vectors++; if (gain !== 16'sd11) begin miscompares++; $display("FAIL lock_gain: got %0d expected 11", gain); end
        vectors++; if (pulses - p0 !== 0) begin miscompares++; $display("FAIL lock_pulses: got %0d expected 0", pulses - p0); end
        $display("lock: gain=%0d", gain);
    endtask

    task automatic test_hold_down;
        int p0;
        SW = 10'd5; p0 = pulses;
        key_down_n = 1'b0;
        tick(15);
        vectors++; if (echo_delay_volume !== 32'd4) begin miscompares++; $display("FAIL hold_first_step: got %0d expected 4", echo_delay_volume); end
        tick(45);
        key_down_n = 1'b1;
        tick(30);
        vectors++; if (echo_delay_volume !== 32'd0) begin miscompares++; $display("FAIL hold_floor: got %0d expected 0", echo_delay_volume); end
        vectors++; if (pulses - p0 !== 5) begin miscompares++; $display("FAIL hold_pulses: got %0d expected 5", pulses - p0); end
        $display("hold_down: volume=%0d", echo_delay_volume);
    endtask

    task automatic test_saturate;
        int p0;
        SW = 10'd4; p0 = pulses;
        key_up_n = 1'b0; tick(120); key_up_n = 1'b1; tick(30);
        vectors++; if (echo_delay_time !== 32'd96000) begin miscompares++; $display("FAIL sat_climb: got %0d expected 96000", echo_delay_time); end
        vectors++; if (pulses - p0 !== 15) begin miscompares++; $display("FAIL sat_climb_pulses: got %0d expected 15", pulses - p0); end
        p0 = pulses;
        tap(1'b1, 1'b0, 10);
        vectors++; if (echo_delay_time !== 32'd96000) begin miscompares++; $display("FAIL sat_max: got %0d expected 96000", echo_delay_time); end
        vectors++; if (pulses - p0 !== 0) begin miscompares++; $display("FAIL sat_max_pulses: got %0d expected 0", pulses - p0); end
        tap(1'b0, 1'b1, 10);
        vectors++; if (echo_delay_time !== 32'd91200) begin miscompares++; $display("FAIL sat_down: got %0d expected 91200", echo_delay_time); end
        $display("saturate: echo_delay_time=%0d", echo_delay_time);
    endtask

    task automatic test_both;
        int p0;
        SW = 10'd3;
        tap(1'b1, 1'b0, 10);
        tap(1'b1, 1'b0, 10);
        vectors++; if (ring_freq !== 32'd1920) begin miscompares++; $display("FAIL both_setup: got %0d expected 1920", ring_freq); end
        p0 = pulses;
        key_up_n = 1'b0; key_down_n = 1'b0;
        tick(12);
        vectors++; if (ring_freq !== 32'd1600) begin miscompares++; $display("FAIL both_restore: got %0d expected 1600", ring_freq); end
        key_up_n = 1'b1; tick(12);
        key_up_n = 1'b0; tick(30);
        vectors++; if (ring_freq !== 32'd1600 || pulses - p0 !== 1) begin
            miscompares++; $display("FAIL both_wait: got ring=%0d pulses=%0d expected 1600 and 1", ring_freq, pulses - p0);
        end
        key_up_n = 1'b1; key_down_n = 1'b1; tick(30);
        tap(1'b1, 1'b0, 10);
        vectors++; if (ring_freq !== 32'd1760) begin miscompares++; $display("FAIL both_rearm: got %0d expected 1760", ring_freq); end
        $display("both: ring_freq=%0d", ring_freq);
    endtask

    task automatic test_sw_change;
        SW = 10'd6;
        key_up_n = 1'b0; tick(15);
        vectors++; if (vib_freq !== 32'd11000) begin miscompares++; $display("FAIL swchg_step: got %0d expected 11000", vib_freq); end
        SW = 10'd2; tick(40);
        vectors++; if (vib_freq !== 32'd11000) begin miscompares++; $display("FAIL swchg_vib: got %0d expected 11000", vib_freq); end
        vectors++; if (tr_freq !== 32'd10000) begin miscompares++; $display("FAIL swchg_tr: got %0d expected 10000", tr_freq); end
        key_up_n = 1'b1; tick(30);
        $display("sw_change: vib=%0d tr=%0d", vib_freq, tr_freq);
    endtask

    task automatic test_reset_mid_hold;
        int p1;
        SW = 10'd6;
        key_up_n = 1'b0; tick(15);
        vectors++; if (vib_freq !== 32'd12000) begin miscompares++; $display("FAIL rst_pre: got %0d expected 12000", vib_freq); end
        reset = 1'b1; tick(2); reset = 1'b0;
        vectors++; if (vib_freq !== 32'd10000 || gain !== 16'sd10 || ring_freq !== 32'd1600 || echo_delay_time !== 32'd24000
                       || echo_delay_volume !== 32'd5 || param_changed !== 1'b0) begin
            miscompares++; $display("FAIL rst_defaults: vib=%0d gain=%0d ring=%0d et=%0d ev=%0d pc=%b expected defaults",
                                    vib_freq, gain, ring_freq, echo_delay_time, echo_delay_volume, param_changed);
        end
        p1 = pulses;
        tick(40);
        vectors++; if (vib_freq !== 32'd10000 || pulses - p1 !== 0) begin
            miscompares++; $display("FAIL rst_held: got vib=%0d pulses=%0d expected 10000 and 0", vib_freq, pulses - p1);
        end
        key_up_n = 1'b1; tick(30);
        tap(1'b1, 1'b0, 10);
        vectors++; if (vib_freq !== 32'd11000) begin miscompares++; $display("FAIL rst_rearm: got %0d expected 11000", vib_freq); end
        $display("reset_mid_hold: vib=%0d", vib_freq);
    endtask

    initial begin
        test_reset();
        test_tap();
        test_glitch();
        test_lock();
        test_hold_down();
        test_saturate();
        test_both();
        test_sw_change();
        test_reset_mid_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
